// File: rtl/intr_ctrl.sv
// Interrupt controller: captures rising edges into pending bits, arbitrates and runs the
// IDLE/REQ/SERVICE handshake with decode. Define INTR_ROUND_ROBIN_EN for round-robin arbitration.
module intr_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_SRC-1:0]         irq_i,
    input  logic [NUM_SRC-1:0]         irq_mask_i,
    input  logic                       enable_i,
    input  logic                       intr_taken_i,
    input  logic                       is_mret_i,
    output logic                       e_intr_o,
    output logic [$clog2(NUM_SRC)-1:0] irq_id_o,
    output logic [NUM_SRC-1:0]         irq_ack_o,
    output logic                       busy_o
);
    localparam int ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] hist;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               grant;
    logic               take;

    assign rise = irq_i & ~hist;
    assign cand = pending & irq_mask_i;
    assign clr  = take ? (NUM_SRC'(1) << irq_id_o) : '0;

`ifdef INTR_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_last;

    // Search begins one past the last acknowledged source and wraps around.
    function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_SRC-1:0] req,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!found && req[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign winner = pick_rr(cand, rr_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last <= ID_W'(NUM_SRC - 1);
        end else if (take) begin
            rr_last <= irq_id_o;
        end
    end
`else
    function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_SRC-1:0] req);
        logic [ID_W-1:0] sel;
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) sel = ID_W'(i);
        end
        return sel;
    endfunction

    assign winner = pick_fixed(cand);
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|cand) begin
                    state_nxt = REQ;
                    grant     = 1'b1;
                end
            end
            REQ: begin
                if (intr_taken_i && enable_i) begin
                    state_nxt = SERVICE;
                    take      = 1'b1;
                end
            end
            SERVICE: begin
                if (is_mret_i && enable_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A rising edge arriving in the ack cycle re-arms the bit the ack is clearing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            pending   <= '0;
            hist      <= '0;
            irq_id_o  <= '0;
            irq_ack_o <= '0;
        end else begin
            state     <= state_nxt;
            hist      <= irq_i;
            pending   <= (pending & ~clr) | rise;
            irq_ack_o <= clr;
            if (grant) irq_id_o <= winner;
        end
    end

    assign e_intr_o = (state == REQ);
    assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized scoreboard bench for intr_ctrl: a behavioural model predicts the outputs after
// every clock edge, and a monitor compares them against the DUT half a cycle later.
module tb_intr_ctrl;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   irq   = '0;
    logic [N-1:0]   mask  = '1;
    logic           en    = 1'b0;
    logic           taken = 1'b0;
    logic           mret  = 1'b0;
    logic           e_intr;
    logic           busy;
    logic [IDW-1:0] id;
    logic [N-1:0]   ack;

    intr_ctrl #(.NUM_SRC(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .irq_mask_i   (mask),
        .enable_i     (en),
        .intr_taken_i (taken),
        .is_mret_i    (mret),
        .e_intr_o     (e_intr),
        .irq_id_o     (id),
        .irq_ack_o    (ack),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         e;
        bit         bsy;
        int         gid;
        bit [N-1:0] a;
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Reference model: pending set, outstanding-request flag, in-handler flag, granted id.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_hist;
    bit [N-1:0] m_rise;
    bit [N-1:0] m_cand;
    bit [N-1:0] m_ack;
    bit         m_req;
    bit         m_isr;
    int         m_id;

`ifdef INTR_ROUND_ROBIN_EN
    int m_last;
    function automatic int pick(input bit [N-1:0] c, input int last);
        for (int k = 1; k <= N; k++) if (c[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction
`else
    function automatic int pick(input bit [N-1:0] c);
        for (int k = 0; k < N; k++) if (c[k]) return k;
        return 0;
    endfunction
`endif

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pend = '0;
            m_hist = '0;
            m_req  = 1'b0;
            m_isr  = 1'b0;
            m_id   = 0;
`ifdef INTR_ROUND_ROBIN_EN
            m_last = N - 1;
`endif
            sb.delete();
            sb.push_back('{e: 1'b0, bsy: 1'b0, gid: 0, a: '0});
        end else begin
            m_rise = irq & ~m_hist;
            m_cand = m_pend & mask;
            m_ack  = '0;
            if (m_req) begin
                if (taken && en) begin
                    m_ack[m_id] = 1'b1;
                    m_req = 1'b0;
                    m_isr = 1'b1;
`ifdef INTR_ROUND_ROBIN_EN
                    m_last = m_id;
`endif
                end
            end else if (m_isr) begin
                if (mret && en) m_isr = 1'b0;
            end else if (m_cand != '0) begin
`ifdef INTR_ROUND_ROBIN_EN
                m_id = pick(m_cand, m_last);
`else
                m_id = pick(m_cand);
`endif
                m_req = 1'b1;
            end
            m_pend = (m_pend & ~m_ack) | m_rise;
            m_hist = irq;
            sb.push_back('{e: m_req, bsy: m_req | m_isr, gid: m_id, a: m_ack});
        end
    end

    initial forever begin
        @(negedge clk);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("e_intr",  int'(e_intr), int'(x.e));
            chk("busy",    int'(busy),   int'(x.bsy));
            chk("irq_id",  int'(id),     x.gid);
            chk("irq_ack", int'(ack),    int'(x.a));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        // single edge on source 2, full handshake
        irq = 4'b0100; mask = '1; en = 1'b1;
        step(4); irq = '0;
        taken = 1'b1; step(1); taken = 1'b0;
        step(3); mret = 1'b1; step(1); mret = 1'b0; step(2);
        // simultaneous edges on 1 and 3
        irq = 4'b1010; step(3);
        taken = 1'b1; step(1); taken = 1'b0; step(2);
        mret = 1'b1; step(1); mret = 1'b0; step(3);
        taken = 1'b1; step(1); taken = 1'b0;
        mret = 1'b1; step(2); mret = 1'b0; irq = '0; step(2);
        // round-robin scenario: grant 1, then pending {0,3}
        irq = 4'b0010; step(3);
        taken = 1'b1; step(1); taken = 1'b0; irq = '0;
        mret = 1'b1; step(1); mret = 1'b0;
        irq = 4'b1001; step(4);
        taken = 1'b1; step(1); taken = 1'b0;
        mret = 1'b1; step(1); mret = 1'b0; step(3);
        taken = 1'b1; step(1); taken = 1'b0;
        mret = 1'b1; step(1); mret = 1'b0; irq = '0; step(2);
        // stall while the decode stage is disabled
        irq = 4'b0001; step(3);
        en = 1'b0; taken = 1'b1; step(3);
        en = 1'b1; step(1); taken = 1'b0;
        mret = 1'b1; step(1); mret = 1'b0; irq = '0; step(2);
        // masked source, then unmasked
        mask = 4'b1110; irq = 4'b0001; step(4);
        mask = '1; step(3);
        taken = 1'b1; step(1); taken = 1'b0; step(2);
        // reset while in SERVICE, then mret ignored in IDLE
        mid_reset();
        mret = 1'b1; step(2); mret = 1'b0; irq = '0; step(3);

        repeat (3000) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            if ($urandom_range(0, 15) == 0) mask = N'($urandom);
            if ($urandom_range(0, 7) == 0) mask = '1;
            taken = ($urandom_range(0, 2) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mret  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) mid_reset();
            else step(1);
        end
        step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL provide parameter: NUM_SRC, 4, number of external interrupt sources (2..16).
REQ-002 SHALL provide port: clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL provide port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: irq_i  input  NUM_SRC  level interrupt lines, synchronous to clk_i.
REQ-005 SHALL provide port: irq_mask_i  input  NUM_SRC  1 = source enabled.
REQ-006 SHALL provide port: enable_i  input  1  decode-stage enable (0 = pipeline stalled).
REQ-007 SHALL provide port: intr_taken_i  input  1  decode stage has accepted the trap (its intr_flag).
REQ-008 SHALL provide port: is_mret_i  input  1  mret decoded in decode stage.
REQ-009 SHALL provide port: e_intr_o  output  1  interrupt request to decode/CSR logic.
REQ-010 SHALL provide port: irq_id_o  output  $clog2(NUM_SRC)  index of the granted source.
REQ-011 SHALL provide port: irq_ack_o  output  NUM_SRC  one-hot, one-cycle acknowledge pulse.
REQ-012 SHALL provide port: busy_o  output  1  high in REQ or SERVICE.

Function
REQ-013 SHALL keep a pending register; bit n set one cycle after a 0->1 transition of irq_i[n].
REQ-014 SHALL clear pending[n] in the cycle irq_ack_o[n] pulses; a new rising edge in that same cycle wins (bit stays set).
REQ-015 SHALL implement FSM IDLE, REQ, SERVICE; reset state IDLE.
REQ-016 IDLE: if (pending & irq_mask_i) != 0, latch winner into irq_id_o and go to REQ next cycle; otherwise stay.
REQ-017 REQ: e_intr_o = 1; grant held even if mask or pending changes; no re-arbitration.
REQ-018 REQ -> SERVICE when intr_taken_i & enable_i; same cycle irq_ack_o[irq_id_o] = 1 and pending bit cleared.
REQ-019 intr_taken_i while enable_i = 0 SHALL be ignored; REQ is held.
REQ-020 SERVICE: e_intr_o = 0; no nesting; go to IDLE when is_mret_i & enable_i.
REQ-021 is_mret_i in IDLE or REQ SHALL be ignored.
REQ-022 Minimum latency, edge on irq_i to e_intr_o: 2 cycles (pending register, then REQ).
REQ-023 irq_id_o SHALL hold its value from the grant until the next grant.
REQ-024 e_intr_o, irq_ack_o and busy_o SHALL be decoded from registered state only; no combinational path from any input.

Reset
REQ-025 rst_i SHALL asynchronously force: FSM = IDLE; pending = 0; edge-detect history = 0; irq_id_o = 0; e_intr_o = 0; irq_ack_o = 0; busy_o = 0.
REQ-026 Reset asserted mid-REQ or mid-SERVICE SHALL drop the request with no ack pulse.
REQ-027 The first edge detect after reset release SHALL compare against the history value 0, so a line already high captures as an edge.

Configuration
REQ-028 With INTR_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority: lowest index wins.
REQ-029 With INTR_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: search starts at (last granted + 1) mod NUM_SRC.
REQ-030 The round-robin pointer SHALL reset to NUM_SRC-1, so source 0 has first priority, and SHALL update only on ack.

Verification
REQ-031 Single edge: irq_i = 4'b0100, mask = 4'hF -> e_intr_o = 1 two cycles later, irq_id_o = 2; intr_taken_i & enable_i -> irq_ack_o = 4'b0100 for one cycle, busy_o stays 1 until is_mret_i.
REQ-032 Simultaneous edges on sources 1 and 3, fixed priority -> grant 1; after mret, grant 3. With INTR_ROUND_ROBIN_EN and last grant = 1, pending {0,3} -> grant 3.
REQ-033 Stall: intr_taken_i = 1 with enable_i = 0 for 3 cycles -> no ack, e_intr_o stays 1; enable_i = 1 -> ack.
REQ-034 Masked source: mask = 4'b1110, edge on source 0 -> no request; set mask bit 0 -> request with irq_id_o = 0.
REQ-035 Reset in SERVICE: assert rst_i asynchronously -> busy_o = 0 and pending = 0 immediately, and no irq_ack_o pulse.
